bubble_collision_ctrl: RTL
==========================

Name: bubble_collision_ctrl

Overview:
- Game-logic stage that sits beside the bubble array and drives it.
- Each pixel it compares the bubble-layer, arrow and player drawing requests and generates the per-pixel arrowHit the bubble array consumes, limited to one pop per frame.
- It also retracts the arrow, tracks remaining bubbles, score, lives and post-hit invulnerability, and runs the level/game FSM.

Parameters:
BUBBLE_COUNT, 7, bubbles per level; the number of pops needed to clear it.
START_LIVES, 3, lives loaded at game start.
POINTS_PER_POP, 10, score increment per pop.
MAX_SCORE, 9999, score saturation value.
INVULN_FRAMES, 60, frames of player immunity after a life is lost.

Ports:
clk  in  1  system clock
resetN  in  1  synchronous active-low reset
startOfFrame  in  1  one-cycle pulse at start of each frame
start  in  1  one-cycle start/continue request (debounced key)
bubbleDR  in  1  bubble layer drawingRequest for current pixel
arrowDR  in  1  arrow drawingRequest for current pixel
playerDR  in  1  player drawingRequest for current pixel
arrowHit  out  1  combinational: current pixel pops a bubble
arrowClear  out  1  registered pulse: retract arrow
lifeLost  out  1  registered pulse: a life was deducted
levelDone  out  1  high while in LEVEL_CLEAR
gameOver  out  1  high while in GAME_OVER
playing  out  1  high while in PLAY (gates bubble start)
score  out  14  current score
lives  out  3  remaining lives
bubblesLeft  out  4  bubbles not yet popped

Behaviour:
- Reset: all registers are sampled on rising clk when resetN=0. Reset values: state=IDLE, score=0, lives=0, bubblesLeft=0, invulnCnt=0, armed=0, playerColl=0. All pulses are 0.
- FSM states are IDLE, PLAY, LEVEL_CLEAR, GAME_OVER.
  - IDLE -start-> PLAY: score=0, lives=START_LIVES, bubblesLeft=BUBBLE_COUNT, invulnCnt=0, armed=1.
  - LEVEL_CLEAR -start-> PLAY: reload bubblesLeft=BUBBLE_COUNT and armed=1; score and lives keep their values.
  - GAME_OVER -start-> PLAY: same as IDLE->PLAY.
  - start is ignored while in PLAY.
- arrowHit = bubbleDR & arrowDR & armed & (state==PLAY). It is same-cycle combinational so the bubble array can pick the bubble at the current pixel.
- Cycle after arrowHit:
  - armed=0.
  - arrowClear=1 for exactly one cycle.
  - bubblesLeft decrements by 1.
  - score = min(score+POINTS_PER_POP, MAX_SCORE).
- startOfFrame sets armed=1 for the next cycle. If arrowHit and startOfFrame occur in the same cycle, the hit is still counted and the set wins, so armed=1. Result: at most one pop per frame, except across that boundary cycle.
- If the decrement takes bubblesLeft to 0, the next state is LEVEL_CLEAR. bubblesLeft never wraps; a decrement at 0 cannot occur because PLAY is left first.
- Player collision: while in PLAY with invulnCnt==0, any cycle where bubbleDR & playerDR are both high sets playerColl=1.
- On startOfFrame in PLAY:
  - If playerColl=1: lives decrements by 1, lifeLost=1 for one cycle, invulnCnt=INVULN_FRAMES, playerColl=0.
  - If lives would reach 0: next state is GAME_OVER.
  - Otherwise, if invulnCnt>0, invulnCnt decrements by 1.
- Pop and player collision in the same frame: both are processed independently.
- Entering LEVEL_CLEAR clears any pending playerColl, so the life is not lost.
- Leaving PLAY clears armed and playerColl; invulnCnt is held.
- Outputs levelDone, gameOver and playing are decoded directly from the state register.
- Widths: invulnCnt is 8 bits. lives decrements only from values ≥1, so it never wraps.
- Reset asserted mid-frame returns to IDLE on the next edge, and all pending pulses are dropped.

Test Plan:
- Reset, start pulse -> playing=1, lives=3, bubblesLeft=7, score=0; all pulses 0.
- bubbleDR=arrowDR=1 held 5 cycles within one frame -> arrowHit high 1 cycle only, arrowClear one pulse, score=10, bubblesLeft=6. After next startOfFrame, overlap -> second pop, score=20.
- 7 pops across 7 frames -> bubblesLeft=0, levelDone=1, score=70; overlap afterwards gives arrowHit=0. Then start -> PLAY, bubblesLeft=7, score=70.
- bubbleDR=playerDR=1 mid-frame -> at next startOfFrame lifeLost pulse, lives=2. Repeat collision over the next 60 frames -> no loss; collision on frame 61 -> lives=1.
- Third life lost -> gameOver=1, lives=0. Then start -> PLAY, lives=3, score=0.
- Score preloaded near max by 1000 pops (multiple levels) -> score holds at 9999; reset asserted mid-PLAY -> next cycle state IDLE, score=0.

Source files
------------

// File: rtl/bubble_collision_ctrl.sv
// Per-pixel arrow/bubble/player collision arbiter plus level/game FSM, score, lives and invulnerability.
// Latency: arrowHit combinational in the same cycle; arrowClear, lifeLost and all counters follow one cycle later.
// Backpressure: none; inputs are consumed every cycle and pulses are never held or replayed.
module bubble_collision_ctrl #(
    parameter int BUBBLE_COUNT   = 7,
    parameter int START_LIVES    = 3,
    parameter int POINTS_PER_POP = 10,
    parameter int MAX_SCORE      = 9999,
    parameter int INVULN_FRAMES  = 60
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        start,
    input  logic        bubbleDR,
    input  logic        arrowDR,
    input  logic        playerDR,
    output logic        arrowHit,
    output logic        arrowClear,
    output logic        lifeLost,
    output logic        levelDone,
    output logic        gameOver,
    output logic        playing,
    output logic [13:0] score,
    output logic [2:0]  lives,
    output logic [3:0]  bubblesLeft
);

    typedef enum logic [1:0] {IDLE, PLAY, LEVEL_CLEAR, GAME_OVER} state_t;

    state_t      state, state_nx;
    logic [13:0] score_nx;
    logic [2:0]  lives_nx;
    logic [3:0]  left_nx;
    logic [7:0]  invulnCnt, invuln_nx;
    logic        armed, armed_nx;
    logic        playerColl, coll_nx;
    logic        clear_nx, lost_nx;
    logic [14:0] score_sum;
    logic [13:0] score_sat;
    logic        last_pop;
    logic        lose;

    assign arrowHit  = bubbleDR & arrowDR & armed & (state == PLAY);
    assign levelDone = (state == LEVEL_CLEAR);
    assign gameOver  = (state == GAME_OVER);
    assign playing   = (state == PLAY);

    assign score_sum = {1'b0, score} + 15'(POINTS_PER_POP);
    assign score_sat = (score_sum > 15'(MAX_SCORE)) ? 14'(MAX_SCORE) : score_sum[13:0];
    assign last_pop  = arrowHit & (bubblesLeft == 4'd1);
    // Clearing the level in the same cycle discards a pending collision
    assign lose      = startOfFrame & playerColl & ~last_pop;

    always_comb begin
        state_nx  = state;
        score_nx  = score;
        lives_nx  = lives;
        left_nx   = bubblesLeft;
        invuln_nx = invulnCnt;
        armed_nx  = armed;
        coll_nx   = playerColl;
        clear_nx  = 1'b0;
        lost_nx   = 1'b0;
        case (state)
            IDLE, GAME_OVER: begin
                if (start) begin
                    state_nx  = PLAY;
                    score_nx  = '0;
                    lives_nx  = 3'(START_LIVES);
                    left_nx   = 4'(BUBBLE_COUNT);
                    invuln_nx = '0;
                    armed_nx  = 1'b1;
                    coll_nx   = 1'b0;
                end
            end
            LEVEL_CLEAR: begin
                if (start) begin
                    state_nx = PLAY;
                    left_nx  = 4'(BUBBLE_COUNT);
                    armed_nx = 1'b1;
                end
            end
            PLAY: begin
                if (arrowHit) begin
                    armed_nx = 1'b0;
                    clear_nx = 1'b1;
                    left_nx  = bubblesLeft - 4'd1;
                    score_nx = score_sat;
                end
                // Frame start re-arms even when a hit lands on the same cycle
                if (startOfFrame) armed_nx = 1'b1;
                if (lose) begin
                    lives_nx  = lives - 3'd1;
                    lost_nx   = 1'b1;
                    invuln_nx = 8'(INVULN_FRAMES);
                    coll_nx   = 1'b0;
                end else begin
                    if (startOfFrame && invulnCnt != 8'd0) invuln_nx = invulnCnt - 8'd1;
                    if (invulnCnt == 8'd0 && bubbleDR && playerDR) coll_nx = 1'b1;
                end
                if (last_pop) begin
                    state_nx = LEVEL_CLEAR;
                    armed_nx = 1'b0;
                    coll_nx  = 1'b0;
                end else if (lose && lives == 3'd1) begin
                    state_nx = GAME_OVER;
                    armed_nx = 1'b0;
                    coll_nx  = 1'b0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state       <= IDLE;
            score       <= '0;
            lives       <= '0;
            bubblesLeft <= '0;
            invulnCnt   <= '0;
            armed       <= 1'b0;
            playerColl  <= 1'b0;
            arrowClear  <= 1'b0;
            lifeLost    <= 1'b0;
        end else begin
            state       <= state_nx;
            score       <= score_nx;
            lives       <= lives_nx;
            bubblesLeft <= left_nx;
            invulnCnt   <= invuln_nx;
            armed       <= armed_nx;
            playerColl  <= coll_nx;
            arrowClear  <= clear_nx;
            lifeLost    <= lost_nx;
        end
    end

endmodule
